// File: rtl/stream_light_multi.sv
// rtl/stream_light_multi.sv - running-light engine with rotate, bounce, fill and dual-dot patterns
module stream_light_multi #(
  parameter int WIDTH = 16,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             stop_i,
  input  logic             reverse_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       speed_i,
  output logic [WIDTH-1:0] led_o,
  output logic             running_o,
  output logic             dir_o
);

  localparam int CW = $clog2(DIV);
  localparam int PW = $clog2(WIDTH / 2);

  localparam logic [1:0] M_ROTATE = 2'd0;
  localparam logic [1:0] M_BOUNCE = 2'd1;
  localparam logic [1:0] M_FILL   = 2'd2;

  localparam logic [CW-1:0] P0_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] P1_M1 = CW'((DIV >> 1) - 1);
  localparam logic [CW-1:0] P2_M1 = CW'((DIV >> 2) - 1);
  localparam logic [CW-1:0] P3_M1 = CW'((DIV >> 3) - 1);

  localparam logic [PW-1:0]    POS_MAX = PW'(WIDTH / 2 - 1);
  localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONE = LSB_ONE << (WIDTH - 1);

  typedef enum logic {S_STOPPED = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q;
  logic             run_q, stop_q, rev_q;
  logic [1:0]       mode_q, speed_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] led_q;
  logic [PW-1:0]    pos_q;
  logic             dir_q;

  logic             run_edge, stop_edge, rev_edge;
  logic             mode_chg, speed_chg;
  logic [CW-1:0]    period_m1;
  logic             tick;
  logic             dir_eff;
  logic [WIDTH-1:0] step_led, init_led;
  logic [PW-1:0]    step_pos;
  logic             step_dir;

  // Two lit LEDs mirrored about the centre of the bank.
  function automatic logic [WIDTH-1:0] dual_led(input logic [PW-1:0] p);
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) begin
      v[i] = (i == int'(p)) || (i == WIDTH - 1 - int'(p));
    end
    return v;
  endfunction

  // Button edges, configuration changes, and the step tick.
  always_comb begin
    run_edge  = run_i & ~run_q;
    stop_edge = stop_i & ~stop_q;
    rev_edge  = reverse_i & ~rev_q;
    mode_chg  = (mode_i != mode_q);
    speed_chg = (speed_i != speed_q);
    case (speed_q)
      2'd0:    period_m1 = P0_M1;
      2'd1:    period_m1 = P1_M1;
      2'd2:    period_m1 = P2_M1;
      default: period_m1 = P3_M1;
    endcase
    // A reverse edge in the tick cycle already steers that step.
    dir_eff = dir_q ^ rev_edge;
    tick    = (state_q == S_RUN) && !stop_edge && !mode_chg && !speed_chg &&
              (cnt_q == period_m1);
  end

  // Seed value loaded when the selected pattern changes.
  always_comb begin
    init_led = '0;
    case (mode_i)
      M_ROTATE, M_BOUNCE: init_led = dir_eff ? MSB_ONE : LSB_ONE;
      M_FILL:             init_led = '0;
      default:            init_led = dual_led('0);
    endcase
  end

  // Next pattern value for the current mode; bounce and dual may flip direction.
  always_comb begin
    step_led = led_q;
    step_pos = pos_q;
    step_dir = dir_eff;
    case (mode_q)
      M_ROTATE: begin
        step_led = dir_eff ? {led_q[0], led_q[WIDTH-1:1]} : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      end
      M_BOUNCE: begin
        if (!dir_eff) begin
          if (led_q[WIDTH-1]) begin
            step_dir = 1'b1;
            step_led = {1'b0, led_q[WIDTH-1:1]};
          end else begin
            step_led = {led_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (led_q[0]) begin
            step_dir = 1'b0;
            step_led = {led_q[WIDTH-2:0], 1'b0};
          end else begin
            step_led = {1'b0, led_q[WIDTH-1:1]};
          end
        end
      end
      M_FILL: begin
        if (&led_q)        step_led = '0;
        else if (!dir_eff) step_led = {led_q[WIDTH-2:0], 1'b1};
        else               step_led = {1'b1, led_q[WIDTH-1:1]};
      end
      default: begin
        if (!dir_eff) begin
          if (pos_q == POS_MAX) begin
            step_dir = 1'b1;
            step_pos = pos_q - PW'(1);
          end else begin
            step_pos = pos_q + PW'(1);
          end
        end else begin
          if (pos_q == '0) begin
            step_dir = 1'b0;
            step_pos = pos_q + PW'(1);
          end else begin
            step_pos = pos_q - PW'(1);
          end
        end
        step_led = dual_led(step_pos);
      end
    endcase
  end

  // Run/stop state machine, step counter and pattern registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_STOPPED;
      run_q   <= 1'b0;
      stop_q  <= 1'b0;
      rev_q   <= 1'b0;
      mode_q  <= M_ROTATE;
      speed_q <= 2'd0;
      cnt_q   <= '0;
      led_q   <= LSB_ONE;
      pos_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      run_q   <= run_i;
      stop_q  <= stop_i;
      rev_q   <= reverse_i;
      mode_q  <= mode_i;
      speed_q <= speed_i;
      dir_q   <= dir_eff;
      if (state_q == S_STOPPED) begin
        // Stop wins when both buttons rise together.
        if (run_edge && !stop_edge) begin
          state_q <= S_RUN;
          cnt_q   <= '0;
        end
      end else begin
        if (stop_edge) begin
          state_q <= S_STOPPED;
          cnt_q   <= '0;
        end else if (mode_chg || speed_chg || tick) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
      if (mode_chg) begin
        led_q <= init_led;
        pos_q <= '0;
      end else if (tick) begin
        led_q <= step_led;
        pos_q <= step_pos;
        dir_q <= step_dir;
      end
    end
  end

  assign led_o     = led_q;
  assign running_o = (state_q == S_RUN);
  assign dir_o     = dir_q;

endmodule

// File: tb/tb_stream_light_multi.sv
// tb/tb_stream_light_multi.sv - scoreboard bench for stream_light_multi
module tb_stream_light_multi;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         run_i = 1'b0;
  logic         stop_i = 1'b0;
  logic         reverse_i = 1'b0;
  logic [1:0]   mode_i = 2'd0;
  logic [1:0]   speed_i = 2'd0;
  logic [W-1:0] led_o;
  logic         running_o;
  logic         dir_o;

  stream_light_multi #(.WIDTH(W), .DIV(D)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .run_i     (run_i),
    .stop_i    (stop_i),
    .reverse_i (reverse_i),
    .mode_i    (mode_i),
    .speed_i   (speed_i),
    .led_o     (led_o),
    .running_o (running_o),
    .dir_o     (dir_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         seg;
    logic [7:0] led;
    logic       dir;
    int         gap;
  } vec_t;

  typedef struct {
    logic [7:0] led;
    logic       dir;
    int         gap;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  logic [7:0] prev_led;
  logic       prev_run;
  int         gap_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int seg, input logic [7:0] led, input logic dir, input int gap);
    vec_t v;
    v.seg = seg;
    v.led = led;
    v.dir = dir;
    v.gap = gap;
    tbl.push_back(v);
  endtask

  task automatic push_seg(input int seg);
    exp_t e;
    foreach (tbl[i]) begin
      if (tbl[i].seg == seg) begin
        e.led = tbl[i].led;
        e.dir = tbl[i].dir;
        e.gap = tbl[i].gap;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse(input int which);
    @(posedge clk_i);
    #1;
    case (which)
      0:       run_i = 1'b1;
      1:       stop_i = 1'b1;
      default: reverse_i = 1'b1;
    endcase
    @(posedge clk_i);
    #1;
    run_i = 1'b0;
    stop_i = 1'b0;
    reverse_i = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk_i);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL step_timeout: %0d steps still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every LED change pops one expected step and checks value, Dir and spacing.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      prev_led = led_o;
      prev_run = running_o;
      gap_cnt  = 0;
    end else begin
      gap_cnt++;
      if (running_o && !prev_run) gap_cnt = 0;
      if (mon_en && led_o !== prev_led) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_step: got led %0h, required no change from %0h", led_o, prev_led);
        end else begin
          e = exp_q.pop_front();
          chk("step_led", 32'(led_o), 32'(e.led));
          chk("step_dir", 32'(dir_o), 32'(e.dir));
          if (e.gap != 0) chk("step_gap", 32'(gap_cnt), 32'(e.gap));
        end
        gap_cnt = 0;
      end
      prev_led = led_o;
      prev_run = running_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // seg 0: rotate left through the bank and wrap
    add(0, 8'h02, 0, 8); add(0, 8'h04, 0, 8); add(0, 8'h08, 0, 8); add(0, 8'h10, 0, 8);
    add(0, 8'h20, 0, 8); add(0, 8'h40, 0, 8); add(0, 8'h80, 0, 8); add(0, 8'h01, 0, 8);
    // seg 1: bounce out to MSB and back; seg 2: after reverse at 0x10
    add(1, 8'h02, 0, 8); add(1, 8'h04, 0, 8); add(1, 8'h08, 0, 8); add(1, 8'h10, 0, 8);
    add(1, 8'h20, 0, 8); add(1, 8'h40, 0, 8); add(1, 8'h80, 0, 8); add(1, 8'h40, 1, 8);
    add(1, 8'h20, 1, 8); add(1, 8'h10, 1, 8);
    add(2, 8'h20, 0, 8);
    // seg 3: fill reload; seg 4: fill and drain; seg 5: fill from the MSB side
    add(3, 8'h00, 0, 0);
    add(4, 8'h01, 0, 8); add(4, 8'h03, 0, 8); add(4, 8'h07, 0, 8); add(4, 8'h0F, 0, 8);
    add(4, 8'h1F, 0, 8); add(4, 8'h3F, 0, 8); add(4, 8'h7F, 0, 8); add(4, 8'hFF, 0, 8);
    add(4, 8'h00, 0, 8);
    add(5, 8'h80, 1, 8); add(5, 8'hC0, 1, 8);
    // seg 6: dual reload keeps Dir=1; seg 7: dual dots, endpoint at pos 0 turns inward
    add(6, 8'h81, 1, 0);
    add(7, 8'h42, 0, 8); add(7, 8'h24, 0, 8); add(7, 8'h18, 0, 8); add(7, 8'h24, 1, 8);
    add(7, 8'h42, 1, 8); add(7, 8'h81, 1, 8); add(7, 8'h42, 0, 8);
    // seg 8: full period after stop/run; seg 9: Speed=3 steps every cycle
    add(8, 8'h24, 0, 8);
    add(9, 8'h18, 0, 0); add(9, 8'h24, 1, 1); add(9, 8'h42, 1, 1); add(9, 8'h81, 1, 1);
    add(9, 8'h42, 0, 1); add(9, 8'h24, 0, 1);

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_led", 32'(led_o), 32'h01);
    chk("reset_running", 32'(running_o), 32'd0);
    chk("reset_dir", 32'(dir_o), 32'd0);
    mon_en = 1'b1;

    // rotate
    push_seg(0);
    pulse(0);
    @(negedge clk_i);
    chk("rotate_running", 32'(running_o), 32'd1);
    wait_empty(120);
    pulse(1);
    @(negedge clk_i);
    chk("rotate_stopped", 32'(running_o), 32'd0);

    // bounce
    mode_i = 2'd1;
    push_seg(1);
    pulse(0);
    wait_empty(150);
    pulse(2);
    @(negedge clk_i);
    chk("bounce_rev_dir", 32'(dir_o), 32'd0);
    chk("bounce_rev_led", 32'(led_o), 32'h10);
    push_seg(2);
    wait_empty(40);
    pulse(1);

    // fill
    push_seg(3);
    mode_i = 2'd2;
    wait_empty(10);
    push_seg(4);
    pulse(0);
    wait_empty(120);
    pulse(2);
    @(negedge clk_i);
    chk("fill_rev_dir", 32'(dir_o), 32'd1);
    push_seg(5);
    wait_empty(40);
    pulse(1);

    // dual: LED shows the reload one cycle after Mode changes
    @(posedge clk_i);
    #1;
    push_seg(6);
    mode_i = 2'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("dual_reload", 32'(led_o), 32'h81);
    push_seg(7);
    pulse(0);
    wait_empty(100);
    pulse(1);

    // Run and Stop rising together while stopped: Stop wins, LED holds
    @(posedge clk_i);
    #1;
    run_i = 1'b1;
    stop_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("run_stop_same", 32'(running_o), 32'd0);
    end
    chk("run_stop_led", 32'(led_o), 32'h42);
    @(posedge clk_i);
    #1;
    run_i = 1'b0;
    stop_i = 1'b0;

    // partial period discarded; a Run edge while running does not restart the count
    pulse(0);
    repeat (3) @(posedge clk_i);
    pulse(1);
    @(negedge clk_i);
    chk("mid_stop", 32'(running_o), 32'd0);
    repeat (3) @(posedge clk_i);
    push_seg(8);
    pulse(0);
    repeat (2) @(posedge clk_i);
    pulse(0);
    wait_empty(40);

    // Speed=3 steps every cycle
    push_seg(9);
    speed_i = 2'd3;
    wait_empty(30);

    // asynchronous reset mid-run, checked between clock edges
    mon_en = 1'b0;
    chk("pre_reset_running", 32'(running_o), 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    chk("async_reset_led", 32'(led_o), 32'h01);
    chk("async_reset_running", 32'(running_o), 32'd0);
    chk("async_reset_dir", 32'(dir_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    speed_i = 2'd0;
    mode_i = 2'd0;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("post_reset_led", 32'(led_o), 32'h01);
    chk("post_reset_running", 32'(running_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
